// File: rtl/reorder_buffer_if.sv
// Reorder buffer port bundle.
//   master : dispatch / execution side (drives alloc_*, wb_*, sees commit/flush)
//   slave  : the reorder buffer itself
// Signals:
//   alloc_valid/ready/idx, alloc_pc/lrd/prd/flags/pred_tgt : dispatch allocation
//   wb_valid/idx/result/taken/target                       : out-of-order writeback
//   commit_valid/lrd/prd/result/store                      : in-order retirement, slot0 oldest
//   flush/flush_pc                                         : mispredict redirect pulse
//   count                                                  : occupied entries
interface reorder_buffer_if #(
  parameter int DEPTH    = 16,
  parameter int COMMIT_W = 2,
  parameter int DATA_W   = 32,
  parameter int PC_W     = 8,
  parameter int PREG_W   = 6,
  parameter int AREG_W   = 5
);
  localparam int IDX_W = $clog2(DEPTH);

  logic                       alloc_valid;
  logic                       alloc_ready;
  logic [IDX_W-1:0]           alloc_idx;
  logic [PC_W-1:0]            alloc_pc;
  logic [AREG_W-1:0]          alloc_lrd;
  logic [PREG_W-1:0]          alloc_prd;
  logic [3:0]                 alloc_flags;
  logic [PC_W-1:0]            alloc_pred_tgt;
  logic                       wb_valid;
  logic [IDX_W-1:0]           wb_idx;
  logic [DATA_W-1:0]          wb_result;
  logic                       wb_taken;
  logic [PC_W-1:0]            wb_target;
  logic [COMMIT_W-1:0]        commit_valid;
  logic [COMMIT_W*AREG_W-1:0] commit_lrd;
  logic [COMMIT_W*PREG_W-1:0] commit_prd;
  logic [COMMIT_W*DATA_W-1:0] commit_result;
  logic [COMMIT_W-1:0]        commit_store;
  logic                       flush;
  logic [PC_W-1:0]            flush_pc;
  logic [IDX_W:0]             count;

  modport master (
    output alloc_valid, alloc_pc, alloc_lrd, alloc_prd, alloc_flags, alloc_pred_tgt,
    output wb_valid, wb_idx, wb_result, wb_taken, wb_target,
    input  alloc_ready, alloc_idx, commit_valid, commit_lrd, commit_prd, commit_result,
    input  commit_store, flush, flush_pc, count
  );

  modport slave (
    input  alloc_valid, alloc_pc, alloc_lrd, alloc_prd, alloc_flags, alloc_pred_tgt,
    input  wb_valid, wb_idx, wb_result, wb_taken, wb_target,
    output alloc_ready, alloc_idx, commit_valid, commit_lrd, commit_prd, commit_result,
    output commit_store, flush, flush_pc, count
  );
endinterface

// File: rtl/reorder_buffer.sv
// In-order-retire reorder buffer.
//   clk, rst : clock, synchronous active-high reset
//   rob_if   : reorder_buffer_if.slave (allocation, writeback, commit, flush, count)
// One allocation per cycle at the tail, out-of-order writeback by tag, up to COMMIT_W
// oldest completed entries retire per cycle. A mispredicted branch retiring squashes
// everything younger and emits a registered one-cycle flush with the redirect PC.
module reorder_buffer #(
  parameter int DEPTH    = 16,
  parameter int COMMIT_W = 2,
  parameter int DATA_W   = 32,
  parameter int PC_W     = 8,
  parameter int PREG_W   = 6,
  parameter int AREG_W   = 5
) (
  input  logic            clk,
  input  logic            rst,
  reorder_buffer_if.slave rob_if
);
  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = IDX_W + 1;

  // head/tail carry a wrap bit so full and empty are distinguishable
  logic [CNT_W-1:0]  head_q, tail_q, count;
  logic [DEPTH-1:0]  valid_q, done_q;
  logic [DEPTH-1:0]  is_br_q, pred_tk_q, is_st_q, taken_q;
  logic [PC_W-1:0]   pc_q       [DEPTH];
  logic [PC_W-1:0]   pred_tgt_q [DEPTH];
  logic [PC_W-1:0]   target_q   [DEPTH];
  logic [AREG_W-1:0] lrd_q      [DEPTH];
  logic [PREG_W-1:0] prd_q      [DEPTH];
  logic [DATA_W-1:0] result_q   [DEPTH];
  logic              flush_q;
  logic [PC_W-1:0]   flush_pc_q;

  logic              full, alloc_fire, wb_fire;
  logic [IDX_W-1:0]  head_idx, tail_idx;
  logic [IDX_W-1:0]  slot_idx [COMMIT_W];
  logic [COMMIT_W-1:0] slot_ok;
  logic [CNT_W-1:0]  n_commit;
  logic              mispred_hit, chain, slot_mp;
  logic [PC_W-1:0]   redirect_pc;
  logic              unused_is_load;

  assign unused_is_load = rob_if.alloc_flags[1];

  assign count    = tail_q - head_q;
  assign full     = (count == CNT_W'(DEPTH));
  assign head_idx = head_q[IDX_W-1:0];
  assign tail_idx = tail_q[IDX_W-1:0];

  assign alloc_fire = rob_if.alloc_valid && rob_if.alloc_ready;
  assign wb_fire    = rob_if.wb_valid && valid_q[rob_if.wb_idx] && !flush_q;

  // Retire slots form a prefix: a slot stops the chain if it is not ready or if it is
  // itself a mispredicted branch (that branch retires, nothing younger does).
  always_comb begin
    chain       = !flush_q && !rst;
    n_commit    = '0;
    mispred_hit = 1'b0;
    redirect_pc = '0;
    slot_ok     = '0;
    slot_mp     = 1'b0;
    for (int k = 0; k < COMMIT_W; k++) begin
      slot_idx[k] = head_idx + IDX_W'(k);
      slot_mp     = is_br_q[slot_idx[k]] &&
                    ((taken_q[slot_idx[k]] != pred_tk_q[slot_idx[k]]) ||
                     (taken_q[slot_idx[k]] && (target_q[slot_idx[k]] != pred_tgt_q[slot_idx[k]])));
      slot_ok[k]  = chain && valid_q[slot_idx[k]] && done_q[slot_idx[k]] && (CNT_W'(k) < count);
      if (slot_ok[k]) begin
        n_commit = n_commit + CNT_W'(1);
        if (slot_mp) begin
          mispred_hit = 1'b1;
          redirect_pc = taken_q[slot_idx[k]] ? target_q[slot_idx[k]] : pc_q[slot_idx[k]] + PC_W'(1);
        end
      end
      chain = slot_ok[k] && !slot_mp;
    end
  end

  always_comb begin
    rob_if.commit_lrd    = '0;
    rob_if.commit_prd    = '0;
    rob_if.commit_result = '0;
    rob_if.commit_store  = '0;
    for (int k = 0; k < COMMIT_W; k++) begin
      rob_if.commit_lrd[k*AREG_W +: AREG_W]    = lrd_q[slot_idx[k]];
      rob_if.commit_prd[k*PREG_W +: PREG_W]    = prd_q[slot_idx[k]];
      rob_if.commit_result[k*DATA_W +: DATA_W] = result_q[slot_idx[k]];
      rob_if.commit_store[k]                   = slot_ok[k] && is_st_q[slot_idx[k]];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q     <= '0;
      tail_q     <= '0;
      valid_q    <= '0;
      done_q     <= '0;
      flush_q    <= 1'b0;
      flush_pc_q <= '0;
    end else begin
      head_q  <= head_q + n_commit;
      flush_q <= 1'b0;
      if (mispred_hit) begin
        // same-cycle alloc and wb are dropped along with every younger entry
        valid_q    <= '0;
        done_q     <= '0;
        tail_q     <= head_q + n_commit;
        flush_q    <= 1'b1;
        flush_pc_q <= redirect_pc;
      end else begin
        if (wb_fire) done_q[rob_if.wb_idx] <= 1'b1;
        for (int k = 0; k < COMMIT_W; k++) begin
          if (slot_ok[k]) valid_q[slot_idx[k]] <= 1'b0;
        end
        if (alloc_fire) begin
          valid_q[tail_idx] <= 1'b1;
          done_q[tail_idx]  <= 1'b0;
          tail_q            <= tail_q + CNT_W'(1);
        end
      end
    end
  end

  // Payload needs no reset: it is only observed through valid/done.
  always_ff @(posedge clk) begin
    if (alloc_fire) begin
      pc_q[tail_idx]       <= rob_if.alloc_pc;
      lrd_q[tail_idx]      <= rob_if.alloc_lrd;
      prd_q[tail_idx]      <= rob_if.alloc_prd;
      pred_tgt_q[tail_idx] <= rob_if.alloc_pred_tgt;
      is_br_q[tail_idx]    <= rob_if.alloc_flags[3];
      pred_tk_q[tail_idx]  <= rob_if.alloc_flags[2];
      is_st_q[tail_idx]    <= rob_if.alloc_flags[0];
    end
    if (wb_fire) begin
      result_q[rob_if.wb_idx] <= rob_if.wb_result;
      taken_q[rob_if.wb_idx]  <= rob_if.wb_taken;
      target_q[rob_if.wb_idx] <= rob_if.wb_target;
    end
  end

  assign rob_if.alloc_ready  = !full && !flush_q && !rst;
  assign rob_if.alloc_idx    = tail_idx;
  assign rob_if.commit_valid = slot_ok;
  assign rob_if.flush        = flush_q;
  assign rob_if.flush_pc     = flush_pc_q;
  assign rob_if.count        = count;
endmodule

// File: tb/tb_reorder_buffer.sv
module tb_reorder_buffer;
  localparam int DEPTH = 16, COMMIT_W = 2, DATA_W = 32, PC_W = 8, PREG_W = 6, AREG_W = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  reorder_buffer_if #(.DEPTH(DEPTH), .COMMIT_W(COMMIT_W), .DATA_W(DATA_W), .PC_W(PC_W),
                      .PREG_W(PREG_W), .AREG_W(AREG_W)) rif ();

  reorder_buffer #(.DEPTH(DEPTH), .COMMIT_W(COMMIT_W), .DATA_W(DATA_W), .PC_W(PC_W),
                   .PREG_W(PREG_W), .AREG_W(AREG_W)) dut (
    .clk    (clk),
    .rst    (rst),
    .rob_if (rif)
  );

  typedef struct {
    logic av; logic [7:0] apc; logic [4:0] alrd; logic [3:0] afl; logic [7:0] atgt;
    logic wv; logic [3:0] widx; logic wtk; logic [7:0] wtgt; logic [31:0] wres;
  } in_t;
  typedef struct {
    logic rdy; logic [3:0] aidx; logic [1:0] cv; logic [4:0] cnt; logic fl; logic [7:0] fpc;
    logic [4:0] lrd0; logic [31:0] res0; logic st0;
  } exp_t;
  typedef struct { in_t i; exp_t e; } vec_t;

  int tests = 0;
  int fails = 0;
  bit track = 1'b0;
  logic [4:0] exp_q[$];
  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic in_t idle();
    in_t v;
    v = '{default: '0};
    return v;
  endfunction

  function automatic in_t al(input logic [7:0] pc, input logic [4:0] lrd, input logic [3:0] fl,
                             input logic [7:0] tgt);
    in_t v;
    v = idle();
    v.av = 1'b1; v.apc = pc; v.alrd = lrd; v.afl = fl; v.atgt = tgt;
    return v;
  endfunction

  function automatic in_t wb(input in_t b, input logic [3:0] idx, input logic tk,
                             input logic [7:0] tgt, input logic [31:0] res);
    in_t v;
    v = b;
    v.wv = 1'b1; v.widx = idx; v.wtk = tk; v.wtgt = tgt; v.wres = res;
    return v;
  endfunction

  function automatic exp_t ex(input logic rdy, input logic [3:0] aidx, input logic [1:0] cv,
                              input logic [4:0] cnt, input logic fl, input logic [7:0] fpc,
                              input logic [4:0] lrd0, input logic [31:0] res0, input logic st0);
    exp_t e;
    e.rdy = rdy; e.aidx = aidx; e.cv = cv; e.cnt = cnt; e.fl = fl; e.fpc = fpc;
    e.lrd0 = lrd0; e.res0 = res0; e.st0 = st0;
    return e;
  endfunction

  function automatic vec_t row(input in_t i, input exp_t e);
    vec_t r;
    r.i = i; r.e = e;
    return r;
  endfunction

  task automatic apply(input in_t v);
    rif.alloc_valid    = v.av;
    rif.alloc_pc       = v.apc;
    rif.alloc_lrd      = v.alrd;
    rif.alloc_prd      = {1'b0, v.alrd};
    rif.alloc_flags    = v.afl;
    rif.alloc_pred_tgt = v.atgt;
    rif.wb_valid       = v.wv;
    rif.wb_idx         = v.widx;
    rif.wb_taken       = v.wtk;
    rif.wb_target      = v.wtgt;
    rif.wb_result      = v.wres;
  endtask

  // One clock: drive after the falling edge, sample 2ns later (well before the rising edge).
  // With track set, every retirement is compared against the allocation-order queue.
  task automatic cycle(input in_t v, input logic r);
    @(negedge clk);
    rst = r;
    apply(v);
    #2;
    if (track) begin
      for (int k = 0; k < COMMIT_W; k++) begin
        if (rif.commit_valid[k]) begin
          if (exp_q.size() == 0) chk("commit_unexpected", 32'(k), 32'hFFFF);
          else chk("commit_order", 32'(rif.commit_lrd[k*AREG_W +: AREG_W]), 32'(exp_q.pop_front()));
        end
      end
      if (v.av && rif.alloc_ready) exp_q.push_back(v.alrd);
    end
  endtask

  task automatic check(input string tag, input exp_t e);
    chk({tag, " alloc_ready"}, 32'(rif.alloc_ready), 32'(e.rdy));
    chk({tag, " alloc_idx"}, 32'(rif.alloc_idx), 32'(e.aidx));
    chk({tag, " commit_valid"}, 32'(rif.commit_valid), 32'(e.cv));
    chk({tag, " count"}, 32'(rif.count), 32'(e.cnt));
    chk({tag, " flush"}, 32'(rif.flush), 32'(e.fl));
    if (e.fl) chk({tag, " flush_pc"}, 32'(rif.flush_pc), 32'(e.fpc));
    if (e.cv[0]) begin
      chk({tag, " commit_lrd0"}, 32'(rif.commit_lrd[4:0]), 32'(e.lrd0));
      chk({tag, " commit_prd0"}, 32'(rif.commit_prd[5:0]), 32'({1'b0, e.lrd0}));
      chk({tag, " commit_result0"}, rif.commit_result[31:0], e.res0);
      chk({tag, " commit_store0"}, 32'(rif.commit_store[0]), 32'(e.st0));
    end
  endtask

  task automatic reset_pulse(input in_t v);
    cycle(v, 1'b1);
    chk("reset alloc_ready", 32'(rif.alloc_ready), 32'd0);
    chk("reset commit_valid", 32'(rif.commit_valid), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    apply(idle());

    // fill to full from reset
    reset_pulse(idle());
    exp_q.delete();
    track = 1'b1;
    cycle(idle(), 1'b0);
    check("post_reset", ex(1, 0, 2'b00, 0, 0, 0, 0, 0, 0));
    for (int i = 0; i < 16; i++) begin
      cycle(al(8'(i), 5'(i), 4'b0000, 8'h00), 1'b0);
      chk($sformatf("fill%0d alloc_idx", i), 32'(rif.alloc_idx), 32'(i));
      chk($sformatf("fill%0d alloc_ready", i), 32'(rif.alloc_ready), 32'd1);
    end
    cycle(idle(), 1'b0);
    chk("full alloc_ready", 32'(rif.alloc_ready), 32'd0);
    chk("full count", 32'(rif.count), 32'd16);

    // retire 10, then allocate 10 across the index wrap
    for (int i = 0; i < 10; i++) cycle(wb(idle(), 4'(i), 1'b0, 8'h00, 32'(i)), 1'b0);
    cycle(idle(), 1'b0);
    cycle(idle(), 1'b0);
    chk("wrap count6", 32'(rif.count), 32'd6);
    for (int i = 0; i < 10; i++) begin
      cycle(al(8'(16 + i), 5'(16 + i), 4'b0000, 8'h00), 1'b0);
      chk($sformatf("wrap%0d alloc_idx", i), 32'(rif.alloc_idx), 32'(i));
      chk($sformatf("wrap%0d alloc_ready", i), 32'(rif.alloc_ready), 32'd1);
    end
    cycle(idle(), 1'b0);
    chk("wrap full ready", 32'(rif.alloc_ready), 32'd0);
    chk("wrap full count", 32'(rif.count), 32'd16);

    // full ROB: retirement and alloc in the same cycle, alloc must wait
    cycle(wb(idle(), 4'd10, 1'b0, 8'h00, 32'h10), 1'b0);
    cycle(al(8'h26, 5'd26, 4'b0000, 8'h00), 1'b0);
    chk("fullret alloc_ready", 32'(rif.alloc_ready), 32'd0);
    chk("fullret commit_valid", 32'(rif.commit_valid), 32'b01);
    chk("fullret count", 32'(rif.count), 32'd16);
    cycle(al(8'h26, 5'd26, 4'b0000, 8'h00), 1'b0);
    chk("fullret2 alloc_ready", 32'(rif.alloc_ready), 32'd1);
    chk("fullret2 alloc_idx", 32'(rif.alloc_idx), 32'd10);
    cycle(idle(), 1'b0);
    chk("fullret3 count", 32'(rif.count), 32'd16);
    for (int j = 0; j < 16; j++) cycle(wb(idle(), 4'((11 + j) % 16), 1'b0, 8'h00, 32'(j)), 1'b0);
    cycle(idle(), 1'b0);
    cycle(idle(), 1'b0);
    chk("drain count", 32'(rif.count), 32'd0);
    chk("drain leftover", 32'(exp_q.size()), 32'd0);
    track = 1'b0;

    // table: ordered retire, mispredict flushes, store release, stale wb
    tbl.push_back(row(al(8'h00, 5'd1, 4'b0000, 8'h00), ex(1, 0, 2'b00, 0, 0, 0, 0, 0, 0)));
    tbl.push_back(row(al(8'h01, 5'd2, 4'b0000, 8'h00), ex(1, 1, 2'b00, 1, 0, 0, 0, 0, 0)));
    tbl.push_back(row(al(8'h02, 5'd3, 4'b0000, 8'h00), ex(1, 2, 2'b00, 2, 0, 0, 0, 0, 0)));
    tbl.push_back(row(wb(idle(), 4'd2, 0, 8'h00, 32'h22), ex(1, 3, 2'b00, 3, 0, 0, 0, 0, 0)));
    tbl.push_back(row(wb(idle(), 4'd1, 0, 8'h00, 32'h11), ex(1, 3, 2'b00, 3, 0, 0, 0, 0, 0)));
    tbl.push_back(row(wb(idle(), 4'd0, 0, 8'h00, 32'h10), ex(1, 3, 2'b00, 3, 0, 0, 0, 0, 0)));
    tbl.push_back(row(idle(), ex(1, 3, 2'b11, 3, 0, 0, 1, 32'h10, 0)));
    tbl.push_back(row(idle(), ex(1, 3, 2'b01, 1, 0, 0, 3, 32'h22, 0)));
    tbl.push_back(row(idle(), ex(1, 3, 2'b00, 0, 0, 0, 0, 0, 0)));
    tbl.push_back(row(al(8'h10, 5'd0, 4'b1000, 8'h11), ex(1, 3, 2'b00, 0, 0, 0, 0, 0, 0)));
    tbl.push_back(row(al(8'h11, 5'd4, 4'b0000, 8'h00), ex(1, 4, 2'b00, 1, 0, 0, 0, 0, 0)));
    tbl.push_back(row(wb(idle(), 4'd4, 0, 8'h00, 32'h44), ex(1, 5, 2'b00, 2, 0, 0, 0, 0, 0)));
    tbl.push_back(row(wb(idle(), 4'd3, 1, 8'h40, 32'hB3), ex(1, 5, 2'b00, 2, 0, 0, 0, 0, 0)));
    tbl.push_back(row(al(8'h12, 5'd9, 4'b0000, 8'h00), ex(1, 5, 2'b01, 2, 0, 0, 0, 32'hB3, 0)));
    tbl.push_back(row(al(8'h12, 5'd9, 4'b0000, 8'h00), ex(0, 4, 2'b00, 0, 1, 8'h40, 0, 0, 0)));
    tbl.push_back(row(idle(), ex(1, 4, 2'b00, 0, 0, 0, 0, 0, 0)));
    tbl.push_back(row(al(8'h20, 5'd5, 4'b1100, 8'h30), ex(1, 4, 2'b00, 0, 0, 0, 0, 0, 0)));
    tbl.push_back(row(al(8'h21, 5'd6, 4'b1100, 8'h50), ex(1, 5, 2'b00, 1, 0, 0, 0, 0, 0)));
    tbl.push_back(row(wb(idle(), 4'd4, 1, 8'h30, 32'h55), ex(1, 6, 2'b00, 2, 0, 0, 0, 0, 0)));
    tbl.push_back(row(wb(idle(), 4'd5, 0, 8'h00, 32'h66), ex(1, 6, 2'b01, 2, 0, 0, 5, 32'h55, 0)));
    tbl.push_back(row(idle(), ex(1, 6, 2'b01, 1, 0, 0, 6, 32'h66, 0)));
    tbl.push_back(row(idle(), ex(0, 6, 2'b00, 0, 1, 8'h22, 0, 0, 0)));
    tbl.push_back(row(wb(al(8'h30, 5'd7, 4'b0001, 8'h00), 4'd6, 0, 8'h00, 32'h99),
                      ex(1, 6, 2'b00, 0, 0, 0, 0, 0, 0)));
    tbl.push_back(row(idle(), ex(1, 7, 2'b00, 1, 0, 0, 0, 0, 0)));
    tbl.push_back(row(wb(idle(), 4'd6, 0, 8'h00, 32'h77), ex(1, 7, 2'b00, 1, 0, 0, 0, 0, 0)));
    tbl.push_back(row(idle(), ex(1, 7, 2'b01, 1, 0, 0, 7, 32'h77, 1)));
    tbl.push_back(row(idle(), ex(1, 7, 2'b00, 0, 0, 0, 0, 0, 0)));

    reset_pulse(idle());
    foreach (tbl[r]) begin
      cycle(tbl[r].i, 1'b0);
      check($sformatf("row%0d", r), tbl[r].e);
    end

    // reset mid-stream with retire-ready entries and live traffic
    reset_pulse(idle());
    for (int i = 0; i < 8; i++) cycle(al(8'(i), 5'(i), 4'b0000, 8'h00), 1'b0);
    cycle(wb(idle(), 4'd0, 1'b0, 8'h00, 32'hA0), 1'b0);
    cycle(wb(idle(), 4'd1, 1'b0, 8'h00, 32'hA1), 1'b0);
    chk("pre_rst count", 32'(rif.count), 32'd8);
    chk("pre_rst commit_valid", 32'(rif.commit_valid), 32'b01);
    reset_pulse(wb(al(8'h08, 5'd8, 4'b0000, 8'h00), 4'd2, 1'b0, 8'h00, 32'hA2));
    cycle(wb(idle(), 4'd5, 1'b0, 8'h00, 32'h55), 1'b0);
    check("post_rst", ex(1, 0, 2'b00, 0, 0, 0, 0, 0, 0));
    cycle(idle(), 1'b0);
    check("stale_wb", ex(1, 0, 2'b00, 0, 0, 0, 0, 0, 0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
